// File: rtl/bch_encode_stream_pkg.sv
// Shared types and default code parameters for the streaming BCH encoder.
// The default code is BCH(63,51,T=2), primitive polynomial x^6+x+1.
package bch_encode_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ECC  = 2'd2
  } enc_state_e;

  localparam int          DEF_ECC_BITS  = 12;
  localparam int          DEF_DATA_BITS = 51;
  // Generator m1(x)*m3(x), octal 12471.
  localparam logic [12:0] DEF_GEN       = 13'h1539;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/bch_encode_stream_lfsr_term.sv
// Advances the systematic-encoder remainder register by one BITS-wide data word,
// consuming data MSB first (remainder of d(x)*x^ECC_BITS modulo the generator).
module bch_encode_stream_lfsr_term #(
  parameter int                BITS     = 8,
  parameter int                ECC_BITS = 12,
  parameter logic [ECC_BITS:0] GEN      = '0
) (
  input  logic [ECC_BITS-1:0] lfsr,
  input  logic [BITS-1:0]     data,
  output logic [ECC_BITS-1:0] lfsr_next
);

  logic [ECC_BITS-1:0] r;
  logic                fb;

  always_comb begin
    r  = lfsr;
    fb = 1'b0;
    for (int i = BITS - 1; i >= 0; i--) begin
      fb = data[i] ^ r[ECC_BITS-1];
      r  = {r[ECC_BITS-2:0], 1'b0} ^ (fb ? GEN[ECC_BITS-1:0] : '0);
    end
    lfsr_next = r;
  end

endmodule

// File: rtl/bch_encode_stream.sv
// Streaming systematic BCH encoder: data words pass through, then parity words.
// Define BCH_ENC_PARITY_INV_EN to invert the valid parity bits (erased page decodes clean).
//
// state | meaning
// IDLE  | waiting for word 0 of a codeword, remainder cleared
// DATA  | accepting data words, remainder accumulating
// ECC   | input closed; output register drains last data word, then parity words
module bch_encode_stream
  import bch_encode_stream_pkg::*;
#(
  parameter int                BITS      = 8,
  parameter int                ECC_BITS  = DEF_ECC_BITS,
  parameter int                DATA_BITS = DEF_DATA_BITS,
  parameter logic [ECC_BITS:0] GEN       = DEF_GEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [BITS-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_valid,
  output logic            out_first,
  output logic            out_last,
  input  logic            out_ready,
  output logic            len_err
);

  localparam int ECC_CYCLES = ceil_div(ECC_BITS, BITS);
  localparam int MAX_WORDS  = DATA_BITS / BITS;
  localparam int ECC_PAD    = ECC_CYCLES * BITS;
  localparam int PAD        = ECC_PAD - ECC_BITS;
  localparam int CW         = $clog2(MAX_WORDS + ECC_CYCLES);

`ifdef BCH_ENC_PARITY_INV_EN
  localparam logic [ECC_PAD-1:0] INV_MASK = {ECC_PAD{1'b1}} << PAD;
`else
  localparam logic [ECC_PAD-1:0] INV_MASK = '0;
`endif

  enc_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q;
  // Remainder kept left-aligned so the last parity word has zero-padded LSBs.
  logic [ECC_PAD-1:0]  lfsr_q;
  logic [ECC_BITS-1:0] lfsr_cur, lfsr_nxt;
  logic [ECC_PAD-1:0]  lfsr_nxt_pad;
  logic                accept, out_hs, last_word, at_max;
  logic                load_par, drain;

  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign at_max    = (cnt_q == CW'(MAX_WORDS - 1));
  assign last_word = in_last || at_max;
  assign len_err   = accept && !in_last && at_max;

  assign lfsr_cur     = (state_q == ST_IDLE) ? '0 : lfsr_q[ECC_PAD-1 -: ECC_BITS];
  assign lfsr_nxt_pad = ECC_PAD'(lfsr_nxt) << PAD;

  bch_encode_stream_lfsr_term #(
    .BITS     (BITS),
    .ECC_BITS (ECC_BITS),
    .GEN      (GEN)
  ) u_term (
    .lfsr      (lfsr_cur),
    .data      (in_data),
    .lfsr_next (lfsr_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DATA: if (accept) state_d = last_word ? ST_ECC : ST_DATA;
      ST_ECC:           if (drain) state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    load_par = 1'b0;
    drain    = 1'b0;
    if (reset_n && state_q != ST_ECC) in_ready = !out_valid || out_ready;
    if (state_q == ST_ECC && out_hs) begin
      if (cnt_q == CW'(ECC_CYCLES)) drain    = 1'b1;
      else                          load_par = 1'b1;
    end
  end

  // In ECC, cnt_q counts parity words already loaded into the output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      lfsr_q    <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
      out_first <= (state_q == ST_IDLE);
      out_last  <= 1'b0;
      lfsr_q    <= last_word ? (lfsr_nxt_pad ^ INV_MASK) : lfsr_nxt_pad;
      cnt_q     <= last_word ? '0 : cnt_q + CW'(1);
    end else if (load_par) begin
      out_data  <= lfsr_q[ECC_PAD-1 -: BITS];
      out_first <= 1'b0;
      out_last  <= (cnt_q == CW'(ECC_CYCLES - 1));
      lfsr_q    <= lfsr_q << BITS;
      cnt_q     <= cnt_q + CW'(1);
    end else if (out_hs) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      if (drain) cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_bch_encode_stream.sv
// Scoreboard bench for bch_encode_stream on BCH(15,7,T=2), g=0x1D1, with BITS=1 and BITS=3.
`timescale 1ns/1ps
module tb_bch_encode_stream;

  localparam logic [8:0] G = 9'h1D1;
`ifdef BCH_ENC_PARITY_INV_EN
  localparam logic [7:0] ZERO_PAR = 8'hFF;
  localparam logic [7:0] ONE_PAR  = 8'h2E;
`else
  localparam logic [7:0] ZERO_PAR = 8'h00;
  localparam logic [7:0] ONE_PAR  = 8'hD1;
`endif

  typedef struct packed {
    logic [2:0] d;
    logic       f;
    logic       l;
  } ow_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] in_data [2];
  logic       in_valid [2];
  logic       in_last [2];
  logic       out_ready [2];
  logic       in_ready [2];
  logic       out_valid [2];
  logic       out_first [2];
  logic       out_last [2];
  logic       len_err [2];
  logic       o_data1;
  logic [2:0] o_data3;

  int     errors = 0;
  int     checks = 0;
  int     rdy_mode = 0;
  longint cyc = 0;
  longint start_cyc = 0;
  ow_t    q0[$];
  ow_t    q1[$];
  logic [2:0] wbuf [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bch_encode_stream #(.BITS(1), .ECC_BITS(8), .DATA_BITS(7), .GEN(G)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data[0][0:0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .out_data(o_data1), .out_valid(out_valid[0]),
    .out_first(out_first[0]), .out_last(out_last[0]), .out_ready(out_ready[0]), .len_err(len_err[0])
  );

  bch_encode_stream #(.BITS(3), .ECC_BITS(8), .DATA_BITS(7), .GEN(G)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .out_data(o_data3), .out_valid(out_valid[1]),
    .out_first(out_first[1]), .out_last(out_last[1]), .out_ready(out_ready[1]), .len_err(len_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Long division of msg(x)*x^8 by g; msg bit k-1 is the earliest bit.
  function automatic logic [7:0] model_par(input logic [7:0] msg, input int k);
    logic [15:0] v;
    v = 16'(msg) << 8;
    for (int i = k + 7; i >= 8; i--)
      if (v[i]) v[i -: 9] = v[i -: 9] ^ G;
    return v[7:0];
  endfunction

  task automatic push(input int idx, input ow_t e);
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic send_cw(input int idx, input int nw, input bit with_last,
                         input bit use_fix, input logic [7:0] fix_par);
    int         b;
    logic [2:0] mask;
    logic [7:0] msg, par;
    logic [8:0] pp;
    ow_t        e;
    bit         got;
    b    = (idx == 0) ? 1 : 3;
    mask = (idx == 0) ? 3'b001 : 3'b111;
    msg  = '0;
    for (int j = 0; j < nw; j++) msg = (msg << b) | {5'b0, wbuf[j] & mask};
    par = use_fix ? fix_par : model_par(msg, nw * b);
`ifdef BCH_ENC_PARITY_INV_EN
    if (!use_fix) par = ~par;
`endif
    for (int j = 0; j < nw; j++) begin
      e.d = wbuf[j] & mask; e.f = (j == 0); e.l = 1'b0;
      push(idx, e);
    end
    if (idx == 0) begin
      for (int p = 7; p >= 0; p--) begin
        e.d = {2'b0, par[p]}; e.f = 1'b0; e.l = (p == 0);
        push(idx, e);
      end
    end else begin
      pp = {par, 1'b0};
      for (int p = 2; p >= 0; p--) begin
        e.d = pp[p*3 +: 3]; e.f = 1'b0; e.l = (p == 0);
        push(idx, e);
      end
    end
    for (int j = 0; j < nw; j++) begin
      in_valid[idx] = 1'b1;
      in_data[idx]  = wbuf[j];
      in_last[idx]  = with_last && (j == nw - 1);
      got = 1'b0;
      for (int t = 0; t < 400 && !got; t++) begin
        @(negedge clk);
        if (in_ready[idx]) begin
          check(idx == 0 ? "d1_len_err" : "d3_len_err", 32'(len_err[idx]),
                32'(!with_last && (j == nw - 1)));
          if (j == 0) start_cyc = cyc;
          got = 1'b1;
        end
        @(posedge clk); #1;
      end
      if (!got) check("accept_timeout", 0, 1);
    end
    in_valid[idx] = 1'b0;
    in_last[idx]  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 4000) begin
      @(posedge clk);
      t++;
    end
    check("drain_left", 32'(q0.size() + q1.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid[0] && out_ready[0]) begin
        ow_t e;
        if (q0.size() == 0) check("d1_extra_word", 1, 0);
        else begin
          e = q0.pop_front();
          check("d1_word", {27'b0, 2'b0, o_data1, out_first[0], out_last[0]}, 32'(e));
        end
      end
      if (out_valid[1] && out_ready[1]) begin
        ow_t e;
        if (q1.size() == 0) check("d3_extra_word", 1, 0);
        else begin
          e = q1.pop_front();
          check("d3_word", {27'b0, o_data3, out_first[1], out_last[1]}, 32'(e));
        end
      end
      if (!(in_valid[0] && in_ready[0])) check("d1_len_idle", 32'(len_err[0]), 0);
      if (!(in_valid[1] && in_ready[1])) check("d3_len_idle", 32'(len_err[1]), 0);
    end
  end

  initial begin
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++)
        out_ready[i] = (rdy_mode == 0) ? 1'b1 :
                       (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t1;
    for (int i = 0; i < 2; i++) begin
      in_data[i] = '0; in_valid[i] = 1'b0; in_last[i] = 1'b0;
    end
    for (int j = 0; j < 8; j++) wbuf[j] = '0;
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready", 32'(in_ready[i]), 0);
      check("rst_out_valid", 32'(out_valid[i]), 0);
      check("rst_out_first", 32'(out_first[i]), 0);
      check("rst_out_last", 32'(out_last[i]), 0);
      check("rst_len_err", 32'(len_err[i]), 0);
    end
    check("rst_data1", 32'(o_data1), 0);
    check("rst_data3", 32'(o_data3), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // all-zero codeword and x^0 message on BITS=1
    send_cw(0, 7, 1'b1, 1'b1, ZERO_PAR);
    wbuf[6] = 3'd1;
    send_cw(0, 7, 1'b1, 1'b1, ONE_PAR);
    wait_drain();

    // 8 words without in_last: closes at 7, 8th starts a new codeword
    for (int j = 0; j < 7; j++) wbuf[j] = 3'($urandom_range(0, 1));
    send_cw(0, 7, 1'b0, 1'b0, 8'h00);
    wbuf[0] = 3'd1;
    send_cw(0, 1, 1'b1, 1'b0, 8'h00);
    wait_drain();

    // BITS=3: back-to-back period, single-word and truncated codewords
    wbuf[0] = 3'd5; wbuf[1] = 3'd2;
    send_cw(1, 2, 1'b1, 1'b0, 8'h00);
    t1 = start_cyc;
    wbuf[0] = 3'd7; wbuf[1] = 3'd1;
    send_cw(1, 2, 1'b1, 1'b0, 8'h00);
    check("b2b_period", 32'(start_cyc - t1), 6);
    wbuf[0] = 3'd6;
    send_cw(1, 1, 1'b1, 1'b0, 8'h00);
    wbuf[0] = 3'd3; wbuf[1] = 3'd4;
    send_cw(1, 2, 1'b0, 1'b0, 8'h00);
    wait_drain();

    // reset asserted while parity is stalled in the output register
    for (int j = 0; j < 7; j++) wbuf[j] = 3'($urandom_range(0, 1));
    send_cw(0, 7, 1'b1, 1'b0, 8'h00);
    @(posedge clk);
    @(posedge clk);
    rdy_mode = 2;
    repeat (3) @(negedge clk);
    check("stall_valid", 32'(out_valid[0]), 1);
    check("stall_in_ready", 32'(in_ready[0]), 0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid[0]), 0);
    check("mid_rst_last", 32'(out_last[0]), 0);
    check("mid_rst_first", 32'(out_first[0]), 0);
    check("mid_rst_data", 32'(o_data1), 0);
    check("mid_rst_in_ready", 32'(in_ready[0]), 0);
    q0.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    rdy_mode = 0;
    wbuf[0] = 3'd1; wbuf[1] = 3'd0; wbuf[2] = 3'd1; wbuf[3] = 3'd1;
    wbuf[4] = 3'd0; wbuf[5] = 3'd0; wbuf[6] = 3'd1;
    send_cw(0, 7, 1'b1, 1'b0, 8'h00);
    wait_drain();

    // random back-pressure, random lengths, occasional truncation
    rdy_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      int nw;
      nw = $urandom_range(1, 7);
      for (int j = 0; j < nw; j++) wbuf[j] = 3'($urandom_range(0, 1));
      send_cw(0, nw, !(nw == 7 && $urandom_range(0, 3) == 0), 1'b0, 8'h00);
    end
    for (int n = 0; n < 200; n++) begin
      int nw;
      nw = $urandom_range(1, 2);
      for (int j = 0; j < nw; j++) wbuf[j] = 3'($urandom_range(0, 7));
      send_cw(1, nw, !(nw == 2 && $urandom_range(0, 3) == 0), 1'b0, 8'h00);
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
